// File: rtl/enc_pkg.sv
// enc_pkg: shared constants and types for the one-hot encoder pipeline.
//   ENC_N_DEFAULT : default number of input lines
//   ERR_CNT_W     : width of the zero/multi event counter
//   ERR_CNT_MAX   : saturation value of that counter
//   enc_status_t  : {zero, multi} status produced alongside each code
package enc_pkg;

   localparam int unsigned ENC_N_DEFAULT = 8;
   localparam int unsigned ERR_CNT_W     = 8;
   localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = 8'hFF;

   typedef struct packed {
      logic zero;
      logic multi;
   } enc_status_t;

endpackage

// File: rtl/enc_prio_comb.sv
// enc_prio_comb: purely combinational N-to-W highest-bit priority encoder.
//   vec_i    [N-1:0] : line vector, bit i is line i
//   code_o   [W-1:0] : index of the highest set bit, 0 when vec_i is zero
//   status_o         : zero = no bit set, multi = more than one bit set
module enc_prio_comb
   import enc_pkg::*;
#(
   parameter  int unsigned N = ENC_N_DEFAULT,
   localparam int unsigned W = $clog2(N)
) (
   input  logic [N-1:0] vec_i,
   output logic [W-1:0] code_o,
   output enc_status_t  status_o
);

   logic seen;

   // Ascending scan: later (higher) set bits overwrite the code, so the
   // highest index wins; a second hit marks the vector as multi-hot.
   always_comb begin
      code_o         = '0;
      seen           = 1'b0;
      status_o.multi = 1'b0;
      for (int unsigned i = 0; i < N; i++) begin
         if (vec_i[i]) begin
            if (seen) status_o.multi = 1'b1;
            seen   = 1'b1;
            code_o = W'(i);
         end
      end
      status_o.zero = !seen;
   end

endmodule

// File: rtl/onehot_encoder_pipe.sv
// onehot_encoder_pipe: 2-stage registered priority encoder with valid/ready
// handshakes on both sides (elastic, no bubbles while the stream flows).
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : input handshake, in_vec captured on transfer
//   in_vec    [N-1:0]   : line vector
//   out_valid/out_ready : output handshake
//   out_code  [W-1:0]   : index of highest set bit (0 for a zero vector)
//   out_zero, out_multi : zero-hot / multi-hot flags
//   err_count [7:0]     : saturating count of flagged output transfers
// Build option: define ENC_ERR_CNT_EN to build the error counter; otherwise
// err_count is tied to zero.
module onehot_encoder_pipe
   import enc_pkg::*;
#(
   parameter  int unsigned N = ENC_N_DEFAULT,
   localparam int unsigned W = $clog2(N)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [N-1:0]         in_vec,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [W-1:0]         out_code,
   output logic                 out_zero,
   output logic                 out_multi,
   output logic [ERR_CNT_W-1:0] err_count
);

   logic                s1_valid_q, s1_valid_d;
   logic [N-1:0]        s1_vec_q, s1_vec_d;
   logic                s2_valid_q, s2_valid_d;
   logic [W-1:0]        code_q, code_d;
   enc_status_t         status_q, status_d;

   logic [W-1:0]        enc_code;
   enc_status_t         enc_status;
   logic                s1_ready, in_xfer, s1_adv;

   enc_prio_comb #(.N(N)) u_enc (
      .vec_i    (s1_vec_q),
      .code_o   (enc_code),
      .status_o (enc_status)
   );

   // Combinational ready chain lets a full, draining pipe accept every cycle.
   assign s1_ready = !s2_valid_q || out_ready;
   assign in_ready = !s1_valid_q || s1_ready;
   assign in_xfer  = in_valid && in_ready;
   assign s1_adv   = s1_valid_q && s1_ready;

   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_vec_d   = s1_vec_q;
      if (in_xfer) begin
         s1_valid_d = 1'b1;
         s1_vec_d   = in_vec;
      end else if (s1_adv) begin
         s1_valid_d = 1'b0;
      end

      s2_valid_d = s2_valid_q;
      code_d     = code_q;
      status_d   = status_q;
      if (s1_adv) begin
         s2_valid_d = 1'b1;
         code_d     = enc_code;
         status_d   = enc_status;
      end else if (s2_valid_q && out_ready) begin
         s2_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q <= 1'b0;
         s1_vec_q   <= '0;
         s2_valid_q <= 1'b0;
         code_q     <= '0;
         status_q   <= '0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_vec_q   <= s1_vec_d;
         s2_valid_q <= s2_valid_d;
         code_q     <= code_d;
         status_q   <= status_d;
      end
   end

   assign out_valid = s2_valid_q;
   assign out_code  = code_q;
   assign out_zero  = status_q.zero;
   assign out_multi = status_q.multi;

`ifdef ENC_ERR_CNT_EN
   logic                 out_xfer;
   logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

   assign out_xfer = s2_valid_q && out_ready;

   always_comb begin
      err_cnt_d = err_cnt_q;
      if (out_xfer && (status_q.zero || status_q.multi) && (err_cnt_q != ERR_CNT_MAX))
         err_cnt_d = err_cnt_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) err_cnt_q <= '0;
      else        err_cnt_q <= err_cnt_d;
   end

   assign err_count = err_cnt_q;
`else
   assign err_count = '0;
`endif

endmodule

// File: tb/tb_onehot_encoder_pipe.sv
module tb_onehot_encoder_pipe;
   import enc_pkg::*;

   localparam int N = 8;
   localparam int W = 3;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [N-1:0] in_vec;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_code;
   logic         out_zero;
   logic         out_multi;
   logic [7:0]   err_count;

   onehot_encoder_pipe #(.N(N)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_vec    (in_vec),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_code  (out_code),
      .out_zero  (out_zero),
      .out_multi (out_multi),
      .err_count (err_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [N-1:0] vec;
      logic [W-1:0] code;
      logic         zero;
      logic         multi;
   } exp_t;

   exp_t        sb[$];
   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;
   int unsigned err_model = 0;   // flagged transfers since reset, saturating
   bit          bp_mode = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Reference: highest set index, zero if none; flags from a plain popcount.
   function automatic exp_t ref_encode(input logic [N-1:0] v);
      exp_t e;
      int   ones;
      e.vec  = v;
      e.code = '0;
      ones   = $countones(v);
      for (int i = N - 1; i >= 0; i--) begin
         if (v[i]) begin
            e.code = W'(i);
            break;
         end
      end
      e.zero  = (ones == 0);
      e.multi = (ones > 1);
      return e;
   endfunction

   function automatic int unsigned exp_err();
`ifdef ENC_ERR_CNT_EN
      return err_model;
`else
      return 0;
`endif
   endfunction

   function automatic int unsigned exp_const(input int unsigned v);
`ifdef ENC_ERR_CNT_EN
      return v;
`else
      return 0;
`endif
   endfunction

   // Monitor: pops the scoreboard on each output transfer, and checks that
   // a stalled output holds its values.
   initial begin
      logic         held = 1'b0;
      logic [W-1:0] h_code;
      logic         h_zero, h_multi;
      exp_t         e;
      forever begin
         @(negedge clk);
         if (rst_n && out_valid) begin
            if (held) begin
               check("stable_code", out_code, h_code);
               check("stable_flags", {out_zero, out_multi}, {h_zero, h_multi});
            end
            if (out_ready) begin
               held = 1'b0;
               if (sb.size() == 0) begin
                  check("unexpected_output", 1, 0);
               end else begin
                  e = sb.pop_front();
                  check($sformatf("code[%02h]", e.vec), out_code, e.code);
                  check($sformatf("zero[%02h]", e.vec), out_zero, e.zero);
                  check($sformatf("multi[%02h]", e.vec), out_multi, e.multi);
                  check("err_count", err_count, exp_err());
                  if ((e.zero || e.multi) && err_model < 255) err_model++;
               end
            end else begin
               held    = 1'b1;
               h_code  = out_code;
               h_zero  = out_zero;
               h_multi = out_multi;
            end
         end else begin
            held = 1'b0;
         end
      end
   end

   // Random backpressure when enabled.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (bp_mode) out_ready = 1'($urandom_range(0, 1));
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Called at posedge+1; returns at posedge+1 after the accepting edge,
   // leaving in_valid high so calls chain back-to-back.
   task automatic send(input logic [N-1:0] v, output int waits);
      in_valid = 1'b1;
      in_vec   = v;
      waits    = 0;
      forever begin
         @(negedge clk);
         if (in_ready) begin
            sb.push_back(ref_encode(v));
            break;
         end
         waits++;
         if (waits > 300) begin
            check("in_ready_timeout", 0, 1);
            break;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      int n = 0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      while (sb.size() != 0 && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("drain_empty", sb.size(), 0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      int           w;
      logic [N-1:0] one;
      one       = 1;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_vec    = '0;
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_out_valid", out_valid, 0);
      check("rst_out_code", out_code, 0);
      check("rst_flags", {out_zero, out_multi}, 0);
      check("rst_err_count", err_count, 0);
      check("rst_in_ready", in_ready, 1);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Single vector, latency
      send(8'b0000_1000, w);
      in_valid = 1'b0;
      @(negedge clk);
      check("latency_edge1_valid", out_valid, 0);
      @(negedge clk);
      check("latency_edge2_valid", out_valid, 1);
      @(posedge clk);
      #1;
      drain();

      // Back-to-back stream of one-hot vectors
      for (int i = 0; i < N; i++) begin
         send(one << i, w);
         check($sformatf("stream_no_stall_%0d", i), w, 0);
      end
      drain();

      // Zero then multi-hot
      send(8'h00, w);
      send(8'hA0, w);
      drain();
      check("err_after_zero_multi", err_count, exp_const(2));

      // Stall with 3 vectors offered
      out_ready = 1'b0;
      send(8'h02, w);
      check("stall_accept1", w, 0);
      send(8'h40, w);
      check("stall_accept2", w, 0);
      in_vec = 8'h81;
      @(negedge clk);
      check("stall_in_ready_low", in_ready, 0);
      repeat (3) @(posedge clk);
      #1;
      out_ready = 1'b1;
      send(8'h81, w);
      drain();

      // Randomized traffic with random backpressure
      bp_mode = 1'b1;
      for (int i = 0; i < 200; i++) begin
         logic [N-1:0] v;
         case ($urandom_range(0, 3))
            0:       v = '0;
            1, 2:    v = one << $urandom_range(0, N - 1);
            default: v = N'($urandom);
         endcase
         send(v, w);
         if ($urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
            repeat ($urandom_range(1, 2)) @(posedge clk);
            #1;
         end
      end
      in_valid = 1'b0;
      bp_mode  = 1'b0;
      @(posedge clk);
      #1;
      drain();

      // Saturation
      for (int i = 0; i < 300; i++) send(8'h00, w);
      drain();
      check("err_saturated", err_count, exp_const(255));

      // Reset while both stages are full
      out_ready = 1'b0;
      send(8'h11, w);
      send(8'h12, w);
      in_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      check("midrst_out_valid", out_valid, 0);
      check("midrst_err_count", err_count, 0);
      check("midrst_in_ready", in_ready, 1);
      check("midrst_out_code", out_code, 0);
      sb.delete();
      err_model = 0;
      #1;
      rst_n     = 1'b1;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      send(8'h10, w);
      drain();
      check("post_rst_err_count", err_count, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
